chess_clock_timer: RTL

- Two-player chess game clock with Fischer increment.
- Counts down each side's MM:SS time in BCD from a parametrised start value and adds a parametrised increment to the mover after each move.
- Raises a per-side flag at 00:00.
- Digit outputs feed the board renderer, which maps each BCD digit to the numeral sprite ROM bases.

---
 rtl/chess_clock_timer_pkg.sv | 22 ++
 rtl/chess_clock_timer_bcd_mmss_counter.sv | 75 +++++++
 rtl/chess_clock_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/chess_clock_timer_pkg.sv
// Shared types and constants for the two-player chess clock.
package chess_clock_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUNNING,
    PAUSED,
    ADDING,
    FLAGGED
  } clk_state_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [15:0] MAX_BCD_TIME = 16'h9959;

  // Whole minutes to {min_tens, min_units, 00} in BCD.
  function automatic logic [15:0] init_bcd(input int unsigned minutes);
    return {4'(minutes / 10), 4'(minutes % 10), 8'h00};
  endfunction

endpackage

// File: rtl/chess_clock_timer_bcd_mmss_counter.sv
// One side's MM:SS time held in BCD: load, borrow-decrement and saturating increment.
module chess_clock_timer_bcd_mmss_counter
  import chess_clock_timer_pkg::*;
#(
  parameter logic [15:0] INIT = 16'h0500
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        dec_i,
  input  logic        inc_i,
  output logic [15:0] value_o,
  output logic        zero_o
);

  logic [15:0] value_q, value_d;
  logic [3:0]  min_t, min_u, sec_t, sec_u;

  always_comb begin
    {min_t, min_u, sec_t, sec_u} = value_q;
    value_d = value_q;
    if (load_i) begin
      value_d = INIT;
    end else if (dec_i && (value_q != 16'h0000)) begin
      if (sec_u != 4'd0) begin
        sec_u = sec_u - 4'd1;
      end else begin
        sec_u = 4'd9;
        if (sec_t != 4'd0) begin
          sec_t = sec_t - 4'd1;
        end else begin
          sec_t = 4'd5;
          if (min_u != 4'd0) begin
            min_u = min_u - 4'd1;
          end else begin
            min_u = 4'd9;
            min_t = min_t - 4'd1;
          end
        end
      end
      value_d = {min_t, min_u, sec_t, sec_u};
    end else if (inc_i && (value_q != MAX_BCD_TIME)) begin
      if (sec_u != 4'd9) begin
        sec_u = sec_u + 4'd1;
      end else begin
        sec_u = 4'd0;
        if (sec_t != 4'd5) begin
          sec_t = sec_t + 4'd1;
        end else begin
          sec_t = 4'd0;
          if (min_u != 4'd9) begin
            min_u = min_u + 4'd1;
          end else begin
            min_u = 4'd0;
            min_t = min_t + 4'd1;
          end
        end
      end
      value_d = {min_t, min_u, sec_t, sec_u};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= INIT;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  // High when the next decrement lands on 00:00.
  assign zero_o  = (value_q == 16'h0001);

endmodule

// File: rtl/chess_clock_timer.sv
// Chess clock with Fischer increment: game FSM, 1 s prescaler and add counter around two BCD counters.
module chess_clock_timer
  import chess_clock_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned INIT_MIN    = 5,
  parameter int unsigned INCREMENT_S = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        move_done_i,
  input  logic        new_game_i,
  output logic [15:0] white_digits_o,
  output logic [15:0] black_digits_o,
  output logic        active_o,
  output logic        running_o,
  output logic [1:0]  flag_o,
  output logic        sec_tick_o
);

  localparam int unsigned     PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [15:0]     INIT_BCD   = init_bcd(INIT_MIN);
  localparam logic [5:0]      ADD_INIT   = 6'(INCREMENT_S);

  clk_state_t    state_q, state_d;
  logic          active_q, active_d;
  logic          running_q, running_d;
  logic          sec_tick_q, sec_tick_d;
  logic [1:0]    flag_q, flag_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    add_q, add_d;

  logic          load, tick;
  logic [1:0]    dec, inc, zero;
  logic [15:0]   side_digits [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    chess_clock_timer_bcd_mmss_counter #(.INIT(INIT_BCD)) u_counter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .dec_i  (dec[gi]),
      .inc_i  (inc[gi]),
      .value_o(side_digits[gi]),
      .zero_o (zero[gi])
    );
  end

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    flag_d     = flag_q;
    presc_d    = presc_q;
    add_d      = add_q;
    sec_tick_d = 1'b0;
    load       = 1'b0;
    dec        = 2'b00;
    inc        = 2'b00;
    if (new_game_i) begin
      state_d  = IDLE;
      active_d = WHITE;
      flag_d   = 2'b00;
      presc_d  = '0;
      add_d    = '0;
      load     = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d  = RUNNING;
          active_d = WHITE;
          presc_d  = '0;
        end
        RUNNING: begin
          // A move beats a coincident tick, so 00:01 plus a move never flags.
          if (move_done_i) begin
            state_d = ADDING;
            add_d   = ADD_INIT;
            presc_d = '0;
          end else if (pause_i) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d         = '0;
            dec[active_q]   = 1'b1;
            sec_tick_d      = 1'b1;
            if (zero[active_q]) begin
              state_d          = FLAGGED;
              flag_d[active_q] = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ADDING: begin
          if (add_q != 6'd0) begin
            inc[active_q] = 1'b1;
            add_d         = add_q - 6'd1;
          end
          // Hand over on the edge carrying the last increment (or at once when none).
          if (add_q <= 6'd1) begin
            state_d  = RUNNING;
            active_d = ~active_q;
          end
        end
        PAUSED:  if (pause_i) state_d = RUNNING;
        FLAGGED: state_d = FLAGGED;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUNNING) || (state_d == ADDING);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      active_q   <= WHITE;
      running_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      flag_q     <= 2'b00;
      presc_q    <= '0;
      add_q      <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      running_q  <= running_d;
      sec_tick_q <= sec_tick_d;
      flag_q     <= flag_d;
      presc_q    <= presc_d;
      add_q      <= add_d;
    end
  end

  assign white_digits_o = side_digits[WHITE];
  assign black_digits_o = side_digits[BLACK];
  assign active_o       = active_q;
  assign running_o      = running_q;
  assign flag_o         = flag_q;
  assign sec_tick_o     = sec_tick_q;

endmodule
